fifo_uart_tx: RTL
=================

# fifo_uart_tx

Downstream drain stage for the RAM-based FIFO. It pops words from the FIFO's read port and serializes each one as an asynchronous UART frame on a single line: start bit, WIDTH data bits LSB first, optional parity bit, one stop bit. It generates its own bit timing from the system clock, issues exactly one pop per frame, and only pops when the FIFO reports non-empty.

## Interface
Parameters:
- WIDTH, 8: data bits per frame; must equal the FIFO's WIDTH.
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥ 2.

Ports (clock and reset first):
- clk  input  1  system clock; single clock domain.
- res_n  input  1  asynchronous, active-low reset.
- enable  input  1  permits new frames to start; has no effect on a frame already in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  WIDTH  FIFO read data; valid the cycle after a pop.
- fifo_shift_out  output  1  one-cycle pop request to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the pop cycle through the last stop-bit cycle.

## Operation
- The FSM has the states IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: tx=1 and busy=0. When enable=1 and fifo_empty=0, drive fifo_shift_out=1 for this cycle only and go to FETCH. fifo_shift_out is combinational from state, enable and fifo_empty, and is 0 in every other state.
- FETCH: busy=1 and tx=1. Latch fifo_rdata into the shift register and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shreg[0]. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. A bit index counts 0..WIDTH-1; after bit WIDTH-1, go to PARITY if parity is compiled in, otherwise go to STOP.
- PARITY: tx is the even parity of the latched word, held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit timer: a down-counter of width $clog2(CLKS_PER_BIT). It reloads to CLKS_PER_BIT-1 on entry to START, DATA, PARITY and STOP, and on every bit boundary. A bit ends when the counter reads 0.
- Bit index: counter of width $clog2(WIDTH)+1; it never wraps within a frame.
- Reset values: tx=1, busy=0, fifo_shift_out=0, state=IDLE, counters=0, shreg=0.

## Timing
- Pop at edge N (fifo_shift_out=1 during cycle N). fifo_rdata is captured at edge N+1. tx falls at edge N+1.
- Frame length, measured from the first start-bit cycle: (WIDTH+2)·CLKS_PER_BIT cycles, or (WIDTH+3)·CLKS_PER_BIT with parity.
- Back-to-back frames: tx stays high for exactly 2 cycles beyond the stop bit (the IDLE and FETCH cycles).
- Boundary conditions:
  - fifo_empty rising mid-frame: ignored; the current frame completes.
  - enable falling mid-frame: the frame completes, and no new pop is issued.
  - fifo_empty=1 in IDLE: no pop; tx stays high indefinitely.
  - Never more than one pop per frame. A pop never occurs while fifo_empty=1.
  - Asynchronous reset mid-frame: tx goes to 1 immediately and the FSM returns to IDLE. The partial frame is lost; the word was already popped and is not restored.
  - CLKS_PER_BIT=2: bit timer is 1 bit wide; every bit lasts 2 cycles.

## Configuration
- FIFO_UART_TX_PARITY_EN:
  - Defined: the PARITY state exists, and an even-parity bit (XOR of all WIDTH data bits) is sent between the last data bit and stop.
  - Undefined: the PARITY state, the parity register and the XOR logic are absent, and DATA goes directly to STOP.

## Structure
- Shared package fifo_uart_pkg:
  - state enum typedef tx_state_t (IDLE, FETCH, START, DATA, PARITY, STOP).
  - constant TX_IDLE_LEVEL=1'b1.
- Sub-module: uart_bit_timer, holding the down-counter with load/expire. It is reusable by a future receive stage.
- Top level instantiates the existing FIFO and fifo_uart_tx side by side. The pop interface is connected directly: fifo_shift_out → shift_out, rdata → fifo_rdata, empty → fifo_empty.

## Test plan
Settings: WIDTH=8, CLKS_PER_BIT=4.
- Single byte, parity off: push 0xA5, enable=1 → one pop. tx: 4 cycles 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles 1. busy is high for 42 cycles.
- Back-to-back: push 0x00, then 0xFF → two pops. The gap between the stop of frame 1 and the start of frame 2 is exactly 2 high cycles; both data patterns are correct.
- Parity on: 0xA5 → parity bit 0; 0x01 → parity bit 1. Frame length is 44 cycles.
- Empty FIFO with enable=1 for 100 cycles → fifo_shift_out never asserts, tx=1, busy=0.
- Enable dropped in the 3rd data bit → the frame completes. No further pop occurs although the FIFO still holds 2 words.
- res_n pulsed low in the 5th data bit → tx=1 and busy=0 asynchronously. After release with a non-empty FIFO, the next word is sent as a clean, complete frame.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO drain / UART serializer stages.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable down-counter that marks the end of one serial bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic res_n,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  // Holds at zero when not reloaded, so expired stays asserted between frames.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CLKS_PER_BIT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and sends it as an 8N1-style UART frame.
// Build option FIFO_UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
import fifo_uart_pkg::*;

module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_shift_out,
  output logic             tx,
  output logic             busy,
  output tx_state_t        dbg_state
);

  localparam int IDX_W = $clog2(WIDTH) + 1;

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] bit_idx;
  logic             load;
  logic             expired;
  logic             last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .res_n   (res_n),
    .load    (load),
    .expired (expired)
  );

  assign last_bit  = (bit_idx == IDX_W'(WIDTH - 1));
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) begin
        shreg   <= fifo_rdata;
        bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_q <= ^fifo_rdata;
`endif
      end else if (state_q == DATA && expired) begin
        shreg <= shreg >> 1;
        if (!last_bit) bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Pop handshake: fifo_shift_out is a single-cycle request, raised only in IDLE
  // while the FIFO is non-empty; the popped word is valid on fifo_rdata in FETCH.
  always_comb begin
    state_d        = state_q;
    fifo_shift_out = 1'b0;
    tx             = TX_IDLE_LEVEL;
    busy           = 1'b1;
    load           = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (enable && !fifo_empty) begin
          fifo_shift_out = 1'b1;
          busy           = 1'b1;
          state_d        = FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_d = START;
      end
      START: begin
        tx = 1'b0;
        if (expired) begin
          load    = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        tx = shreg[0];
        if (expired) begin
          load = 1'b1;
          if (last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (expired) begin
          load    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (expired) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
